// File: rtl/spi_reg_initiator_if.sv
// Register-bank application bus between the SPI initiator and the register bank.
// master: drives the request side (spi_reg_initiator); slave: the register bank.
interface spi_reg_initiator_if #(
  parameter int ADDR_W = 3,
  parameter int REG_W  = 8
);
  logic              wr_rdn;
  logic [ADDR_W-1:0] addr;
  logic [REG_W-1:0]  wdata;
  logic              we;
  logic              req;
  logic [REG_W-1:0]  rdata;
  logic              ack;
  logic              err;

  modport master (output wr_rdn, addr, wdata, we, req, input rdata, ack, err);
  modport slave  (input wr_rdn, addr, wdata, we, req, output rdata, ack, err);
endinterface

// File: rtl/spi_reg_initiator.sv
// SPI mode-0 target that turns 2-byte frames {rw,a[6:0]},{data} into single
// register-bank transactions. SPI pins are oversampled through 2-flop
// synchronizers; f_clk must be >= 16x f_sclk.
// Optional macro SPI_STATUS_BYTE_EN: byte0 on MISO returns sticky
// {err_seen, timeout_seen, 6'b0}, cleared once byte0 has been shifted out.
module spi_reg_initiator #(
  parameter int ADDR_W  = 3,
  parameter int REG_W   = 8,
  parameter int TIMEOUT = 4
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic                ena,
  input  logic                spi_cs_n,
  input  logic                spi_sclk,
  input  logic                spi_mosi,
  output logic                spi_miso,
  output logic                spi_miso_oe,
  spi_reg_initiator_if.master bus
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, CMD, RD_REQ, DATA, WR_REQ, WAIT_CS} state_e;

  state_e            state_q, state_d;
  logic [1:0]        cs_sync_q, cs_sync_d;
  logic [1:0]        sclk_sync_q, sclk_sync_d;
  logic [1:0]        mosi_sync_q, mosi_sync_d;
  logic              sclk_prev_q, sclk_prev_d;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [REG_W-1:0]  rx_q, rx_d;
  logic [REG_W-1:0]  tx_q, tx_d;
  logic              miso_q, miso_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [REG_W-1:0]  wdata_q, wdata_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              fall8_q, fall8_d;
`ifdef SPI_STATUS_BYTE_EN
  logic              err_seen_q, err_seen_d;
  logic              timeout_seen_q, timeout_seen_d;
`endif

  logic             cs_s, sclk_s, mosi_s, rise, fall;
  logic             in_req, to_hit, req_done;
  logic [REG_W-1:0] rx_next, tx_sh, ld_data;

  assign cs_s    = cs_sync_q[1];
  assign sclk_s  = sclk_sync_q[1];
  assign mosi_s  = mosi_sync_q[1];
  assign rise    = sclk_s & ~sclk_prev_q;
  assign fall    = ~sclk_s & sclk_prev_q;
  assign in_req  = (state_q == RD_REQ) || (state_q == WR_REQ);
  // The TIMEOUT-th request cycle is the last; ack in that cycle still wins.
  assign to_hit  = (to_cnt_q == TO_W'(TIMEOUT - 1));
  assign req_done = in_req & (bus.ack | to_hit);
  assign rx_next = {rx_q[REG_W-2:0], mosi_s};
  assign tx_sh   = {tx_q[REG_W-2:0], 1'b0};
  assign ld_data = (bus.ack & ~bus.err) ? bus.rdata : {REG_W{1'b1}};

  // Synchronizer and edge-detect next values
  always_comb begin
    cs_sync_d   = {cs_sync_q[0], spi_cs_n};
    sclk_sync_d = {sclk_sync_q[0], spi_sclk};
    mosi_sync_d = {mosi_sync_q[0], spi_mosi};
    sclk_prev_d = sclk_s;
  end

  // Synchronizer flops; cs_n resets inactive so MISO stays disabled
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cs_sync_q   <= 2'b11;
      sclk_sync_q <= 2'b00;
      mosi_sync_q <= 2'b00;
      sclk_prev_q <= 1'b0;
    end else begin
      cs_sync_q   <= cs_sync_d;
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state; cs_n rising aborts shifting but never an issued request
  always_comb begin
    state_d = state_q;
    if (!ena) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (!cs_s) state_d = CMD;
        CMD: begin
          if (cs_s) state_d = IDLE;
          else if (rise && bit_cnt_q == 5'd7) state_d = rx_next[REG_W-1] ? DATA : RD_REQ;
        end
        RD_REQ:  if (req_done) state_d = cs_s ? IDLE : DATA;
        DATA: begin
          if (cs_s) state_d = IDLE;
          else if (rise && bit_cnt_q == 5'd15) state_d = rw_q ? WR_REQ : WAIT_CS;
        end
        WR_REQ:  if (req_done) state_d = cs_s ? IDLE : WAIT_CS;
        WAIT_CS: if (cs_s) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs; req/we gated by ena so they drop in the same cycle
  always_comb begin
    bus.req     = ena & in_req;
    bus.wr_rdn  = ena & (state_q == WR_REQ);
    bus.we      = bus.req & bus.wr_rdn;
    bus.addr    = addr_q;
    bus.wdata   = wdata_q;
    spi_miso    = miso_q;
    spi_miso_oe = ~cs_s;
  end

  // Datapath: shift registers, bit/timeout counters, MISO, latched fields
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    miso_d    = miso_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    to_cnt_d  = to_cnt_q;
    fall8_d   = fall8_q;
`ifdef SPI_STATUS_BYTE_EN
    err_seen_d     = err_seen_q;
    timeout_seen_d = timeout_seen_q;
`endif
    if (!ena) begin
      bit_cnt_d = '0;
      rx_d      = '0;
      tx_d      = '0;
      miso_d    = 1'b0;
      rw_d      = 1'b0;
      addr_d    = '0;
      wdata_d   = '0;
      to_cnt_d  = '0;
      fall8_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          bit_cnt_d = '0;
          rx_d      = '0;
          to_cnt_d  = '0;
          fall8_d   = 1'b0;
          tx_d      = '0;
          miso_d    = 1'b0;
`ifdef SPI_STATUS_BYTE_EN
          // First status bit must be on MISO before the first rising edge
          if (!cs_s) begin
            tx_d   = {err_seen_q, timeout_seen_q, {(REG_W-2){1'b0}}};
            miso_d = err_seen_q;
          end
`endif
        end
        CMD: begin
          if (rise) begin
            rx_d      = rx_next;
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              rw_d     = rx_next[REG_W-1];
              addr_d   = rx_next[ADDR_W-1:0];
              to_cnt_d = '0;
              tx_d     = '0;
              miso_d   = 1'b0;
`ifdef SPI_STATUS_BYTE_EN
              err_seen_d     = 1'b0;
              timeout_seen_d = 1'b0;
`endif
            end
          end else if (fall && bit_cnt_q != 5'd0) begin
            tx_d   = tx_sh;
            miso_d = tx_sh[REG_W-1];
          end
        end
        RD_REQ: begin
          to_cnt_d = to_cnt_q + TO_W'(1);
          if (fall) fall8_d = 1'b1;
          if (req_done) begin
            to_cnt_d = '0;
            tx_d     = ld_data;
            // 8th falling edge already passed: present bit7 right away
            if (fall8_q || fall) miso_d = ld_data[REG_W-1];
          end
        end
        DATA: begin
          if (rise) begin
            rx_d      = rx_next;
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd15) begin
              miso_d = 1'b0;
              if (rw_q) begin
                wdata_d  = rx_next;
                to_cnt_d = '0;
              end
            end
          end else if (fall) begin
            if (!fall8_q) begin
              fall8_d = 1'b1;
              miso_d  = tx_q[REG_W-1];
            end else begin
              tx_d   = tx_sh;
              miso_d = tx_sh[REG_W-1];
            end
          end
        end
        WR_REQ: begin
          to_cnt_d = to_cnt_q + TO_W'(1);
          miso_d   = 1'b0;
          if (req_done) to_cnt_d = '0;
        end
        default: miso_d = 1'b0;
      endcase
`ifdef SPI_STATUS_BYTE_EN
      if (req_done) begin
        if (bus.ack & bus.err) err_seen_d     = 1'b1;
        if (!bus.ack)          timeout_seen_d = 1'b1;
      end
`endif
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      bit_cnt_q <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      miso_q    <= 1'b0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      to_cnt_q  <= '0;
      fall8_q   <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      miso_q    <= miso_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      to_cnt_q  <= to_cnt_d;
      fall8_q   <= fall8_d;
    end
  end

`ifdef SPI_STATUS_BYTE_EN
  // Sticky bus status flags reported in byte0
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      err_seen_q     <= 1'b0;
      timeout_seen_q <= 1'b0;
    end else begin
      err_seen_q     <= err_seen_d;
      timeout_seen_q <= timeout_seen_d;
    end
  end
`endif

endmodule

// File: tb/tb_spi_reg_initiator.sv
// Bench for spi_reg_initiator: SPI master driver, register-bank responder and
// a frame-level reference model (memory array + sticky status flags).
module tb_spi_reg_initiator;
  localparam int ADDR_W  = 3;
  localparam int REG_W   = 8;
  localparam int TIMEOUT = 4;
  localparam int NREG    = 1 << ADDR_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstb, ena, spi_cs_n, spi_sclk, spi_mosi, spi_miso, spi_miso_oe;

  spi_reg_initiator_if #(.ADDR_W(ADDR_W), .REG_W(REG_W)) bus_if ();

  spi_reg_initiator #(.ADDR_W(ADDR_W), .REG_W(REG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rstb       (rstb),
    .ena        (ena),
    .spi_cs_n   (spi_cs_n),
    .spi_sclk   (spi_sclk),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .spi_miso_oe(spi_miso_oe),
    .bus        (bus_if.master)
  );

  int errors = 0;
  int checks = 0;

  // responder state (0: ack at once, 1: ack after resp_delay cycles, 2: never ack, 3: ack+err)
  int resp_mode  = 0;
  int resp_delay = 0;
  int req_cycles = 0;
  int txn_cnt    = 0;
  int last_len   = 0;
  int we_bad     = 0;
  logic              last_wr = 1'b0;
  logic [ADDR_W-1:0] last_addr = '0;
  logic [7:0]        last_wdata = '0;
  logic [7:0]        bank [NREG] = '{default: 8'h00};

  // reference model
  logic [7:0] ref_mem [NREG] = '{default: 8'h00};
  bit m_err = 1'b0;
  bit m_to  = 1'b0;

  // register bank responder, acting on the negative edge
  always @(negedge clk) begin
    if (bus_if.we !== (bus_if.req & bus_if.wr_rdn)) we_bad++;
    if (bus_if.req === 1'b1) begin
      if (req_cycles == 0) begin
        txn_cnt++;
        last_wr    = bus_if.wr_rdn;
        last_addr  = bus_if.addr;
        last_wdata = bus_if.wdata;
      end
      req_cycles++;
      last_len     = req_cycles;
      bus_if.ack   = (resp_mode == 0) || (resp_mode == 3) || (resp_mode == 1 && req_cycles > resp_delay);
      bus_if.err   = (resp_mode == 3);
      bus_if.rdata = bank[bus_if.addr];
      if (bus_if.ack && !bus_if.err && bus_if.wr_rdn) bank[bus_if.addr] = bus_if.wdata;
    end else begin
      req_cycles   = 0;
      bus_if.ack   = 1'b0;
      bus_if.err   = 1'b0;
      bus_if.rdata = 8'h00;
    end
  end

  // SPI mode-0 master; half period = 10 clk. hold: stop right after the last rising edge
  task automatic spi_frame(input logic [7:0] b0, input logic [7:0] b1, input int nbits,
                           input bit hold, output logic [7:0] m0, output logic [7:0] m1);
    m0 = 8'h00;
    m1 = 8'h00;
    spi_cs_n = 1'b0;
    repeat (12) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = (i < 8) ? b0[7-i] : b1[15-i];
      repeat (10) @(negedge clk);
      if (i < 8) m0[7-i] = spi_miso;
      else       m1[15-i] = spi_miso;
      spi_sclk = 1'b1;
      if (hold && i == nbits - 1) return;
      repeat (10) @(negedge clk);
      spi_sclk = 1'b0;
    end
    repeat (10) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  // run one frame and advance the model; e0/e1 are the model's MISO bytes
  task automatic do_frame(input logic [7:0] b0, input logic [7:0] b1, input int mode,
                          input int delay, input int nbits, input bit hold,
                          output logic [7:0] m0, output logic [7:0] m1,
                          output logic [7:0] e0, output logic [7:0] e1);
    int a;
    bit ok;
    a  = int'(b0) % NREG;
    ok = (mode == 0) || (mode == 1);
    resp_mode  = mode;
    resp_delay = delay;
`ifdef SPI_STATUS_BYTE_EN
    e0 = {m_err, m_to, 6'b0};
`else
    e0 = 8'h00;
`endif
    e1 = ok ? ref_mem[a] : 8'hFF;
    spi_frame(b0, b1, nbits, hold, m0, m1);
    if (nbits >= 8) begin
      m_err = 1'b0;
      m_to  = 1'b0;
    end
    if (nbits == 16 && !hold) begin
      if (mode == 3) m_err = 1'b1;
      if (mode == 2) m_to  = 1'b1;
      if (ok && b0[7]) ref_mem[a] = b1;
    end
  endtask

  task automatic test_reset();
    rstb = 1'b0; ena = 1'b1; spi_cs_n = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    checks++; if (bus_if.req !== 1'b0)    begin errors++; $display("FAIL reset_req got %b want 0", bus_if.req); end
    checks++; if (bus_if.we !== 1'b0)     begin errors++; $display("FAIL reset_we got %b want 0", bus_if.we); end
    checks++; if (bus_if.wr_rdn !== 1'b0) begin errors++; $display("FAIL reset_wr_rdn got %b want 0", bus_if.wr_rdn); end
    checks++; if (bus_if.addr !== '0)     begin errors++; $display("FAIL reset_addr got %h want 0", bus_if.addr); end
    checks++; if (bus_if.wdata !== 8'h00) begin errors++; $display("FAIL reset_wdata got %h want 00", bus_if.wdata); end
    checks++; if (spi_miso !== 1'b0)      begin errors++; $display("FAIL reset_miso got %b want 0", spi_miso); end
    checks++; if (spi_miso_oe !== 1'b0)   begin errors++; $display("FAIL reset_miso_oe got %b want 0", spi_miso_oe); end
    rstb = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_write_basic();
    logic [7:0] m0, m1, e0, e1;
    int t0;
    t0 = txn_cnt;
    do_frame(8'h83, 8'h5A, 0, 0, 16, 1'b0, m0, m1, e0, e1);
    checks++; if (txn_cnt - t0 !== 1)     begin errors++; $display("FAIL wr_txn_count got %0d want 1", txn_cnt - t0); end
    checks++; if (last_wr !== 1'b1)       begin errors++; $display("FAIL wr_wr_rdn got %b want 1", last_wr); end
    checks++; if (last_addr !== 3'd3)     begin errors++; $display("FAIL wr_addr got %h want 3", last_addr); end
    checks++; if (last_wdata !== 8'h5A)   begin errors++; $display("FAIL wr_wdata got %h want 5a", last_wdata); end
    checks++; if (last_len !== 1)         begin errors++; $display("FAIL wr_req_len got %0d want 1", last_len); end
    checks++; if (bus_if.req !== 1'b0)    begin errors++; $display("FAIL wr_idle_req got %b want 0", bus_if.req); end
    checks++; if (spi_miso_oe !== 1'b0)   begin errors++; $display("FAIL wr_idle_oe got %b want 0", spi_miso_oe); end
  endtask

  task automatic test_write_read();
    logic [7:0] m0, m1, e0, e1;
    int t0;
    do_frame(8'h81, 8'hC3, 1, 1, 16, 1'b0, m0, m1, e0, e1);
    t0 = txn_cnt;
    do_frame(8'h01, 8'h00, 1, 2, 16, 1'b0, m0, m1, e0, e1);
    checks++; if (m1 !== 8'hC3)           begin errors++; $display("FAIL rd_miso_byte1 got %h want c3", m1); end
    checks++; if (txn_cnt - t0 !== 1)     begin errors++; $display("FAIL rd_txn_count got %0d want 1", txn_cnt - t0); end
    checks++; if (last_wr !== 1'b0)       begin errors++; $display("FAIL rd_wr_rdn got %b want 0", last_wr); end
    checks++; if (last_addr !== 3'd1)     begin errors++; $display("FAIL rd_addr got %h want 1", last_addr); end
  endtask

  task automatic test_timeout();
    logic [7:0] m0, m1, e0, e1, want0;
    do_frame(8'h05, 8'h00, 2, 0, 16, 1'b0, m0, m1, e0, e1);
    checks++; if (m1 !== 8'hFF)           begin errors++; $display("FAIL to_miso_byte1 got %h want ff", m1); end
    checks++; if (last_len !== TIMEOUT)   begin errors++; $display("FAIL to_req_len got %0d want %0d", last_len, TIMEOUT); end
    do_frame(8'h02, 8'h00, 0, 0, 16, 1'b0, m0, m1, e0, e1);
`ifdef SPI_STATUS_BYTE_EN
    want0 = 8'h40;
`else
    want0 = 8'h00;
`endif
    checks++; if (m0 !== want0)           begin errors++; $display("FAIL to_status_byte0 got %h want %h", m0, want0); end
  endtask

  task automatic test_err();
    logic [7:0] m0, m1, e0, e1, want0;
    do_frame(8'h06, 8'h00, 3, 0, 16, 1'b0, m0, m1, e0, e1);
    checks++; if (m1 !== 8'hFF)           begin errors++; $display("FAIL err_miso_byte1 got %h want ff", m1); end
    do_frame(8'h02, 8'h00, 0, 0, 16, 1'b0, m0, m1, e0, e1);
`ifdef SPI_STATUS_BYTE_EN
    want0 = 8'h80;
`else
    want0 = 8'h00;
`endif
    checks++; if (m0 !== want0)           begin errors++; $display("FAIL err_status_byte0 got %h want %h", m0, want0); end
  endtask

  task automatic test_abort();
    logic [7:0] m0, m1, e0, e1;
    int t0;
    t0 = txn_cnt;
    do_frame(8'h84, 8'h77, 0, 0, 12, 1'b0, m0, m1, e0, e1);
    checks++; if (txn_cnt - t0 !== 0)     begin errors++; $display("FAIL abort_no_txn got %0d want 0", txn_cnt - t0); end
    t0 = txn_cnt;
    do_frame(8'h82, 8'h11, 0, 0, 16, 1'b0, m0, m1, e0, e1);
    checks++; if (txn_cnt - t0 !== 1)     begin errors++; $display("FAIL abort_next_txn got %0d want 1", txn_cnt - t0); end
    checks++; if (last_addr !== 3'd2)     begin errors++; $display("FAIL abort_next_addr got %h want 2", last_addr); end
    checks++; if (last_wdata !== 8'h11)   begin errors++; $display("FAIL abort_next_wdata got %h want 11", last_wdata); end
    do_frame(8'h04, 8'h00, 0, 0, 16, 1'b0, m0, m1, e0, e1);
    checks++; if (m1 !== 8'h00)           begin errors++; $display("FAIL abort_addr4_unwritten got %h want 00", m1); end
  endtask

  task automatic test_rst_mid();
    logic [7:0] m0, m1, e0, e1;
    bit seen;
    seen = 1'b0;
    do_frame(8'h85, 8'h3C, 2, 0, 16, 1'b1, m0, m1, e0, e1);
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus_if.req === 1'b1) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL rstmid_req_seen got 0 want 1"); end
    rstb = 1'b0;
    #1;
    checks++; if (bus_if.req !== 1'b0)    begin errors++; $display("FAIL rstmid_req got %b want 0", bus_if.req); end
    checks++; if (bus_if.we !== 1'b0)     begin errors++; $display("FAIL rstmid_we got %b want 0", bus_if.we); end
    checks++; if (bus_if.addr !== '0)     begin errors++; $display("FAIL rstmid_addr got %h want 0", bus_if.addr); end
    checks++; if (bus_if.wdata !== 8'h00) begin errors++; $display("FAIL rstmid_wdata got %h want 00", bus_if.wdata); end
    checks++; if (spi_miso_oe !== 1'b0)   begin errors++; $display("FAIL rstmid_oe got %b want 0", spi_miso_oe); end
    spi_sclk = 1'b0;
    spi_cs_n = 1'b1;
    m_err = 1'b0;
    m_to  = 1'b0;
    repeat (4) @(negedge clk);
    rstb = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_ena_mid();
    logic [7:0] m0, m1, e0, e1;
    bit seen;
    int t0;
    seen = 1'b0;
    do_frame(8'h86, 8'hA5, 2, 0, 16, 1'b1, m0, m1, e0, e1);
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus_if.req === 1'b1) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL enamid_req_seen got 0 want 1"); end
    checks++; if (spi_miso_oe !== 1'b1)   begin errors++; $display("FAIL enamid_oe_active got %b want 1", spi_miso_oe); end
    ena = 1'b0;
    #1;
    checks++; if (bus_if.req !== 1'b0)    begin errors++; $display("FAIL enamid_req got %b want 0", bus_if.req); end
    checks++; if (bus_if.we !== 1'b0)     begin errors++; $display("FAIL enamid_we got %b want 0", bus_if.we); end
    repeat (3) @(negedge clk);
    checks++; if (bus_if.addr !== '0)     begin errors++; $display("FAIL enamid_addr got %h want 0", bus_if.addr); end
    checks++; if (bus_if.wdata !== 8'h00) begin errors++; $display("FAIL enamid_wdata got %h want 00", bus_if.wdata); end
    checks++; if (spi_miso !== 1'b0)      begin errors++; $display("FAIL enamid_miso got %b want 0", spi_miso); end
    spi_sclk = 1'b0;
    spi_cs_n = 1'b1;
    repeat (6) @(negedge clk);
    ena = 1'b1;
    repeat (4) @(negedge clk);
    t0 = txn_cnt;
    do_frame(8'h87, 8'h99, 0, 0, 16, 1'b0, m0, m1, e0, e1);
    checks++; if (txn_cnt - t0 !== 1)     begin errors++; $display("FAIL enamid_recover_txn got %0d want 1", txn_cnt - t0); end
    checks++; if (last_wdata !== 8'h99)   begin errors++; $display("FAIL enamid_recover_wdata got %h want 99", last_wdata); end
  endtask

  task automatic test_random();
    logic [7:0] b0, b1, m0, m1, e0, e1;
    int mode, delay, t0;
    for (int n = 0; n < 24; n++) begin
      b0    = 8'($urandom);
      b1    = 8'($urandom);
      mode  = int'($urandom_range(0, 3));
      delay = int'($urandom_range(0, 3));
      t0    = txn_cnt;
      do_frame(b0, b1, mode, delay, 16, 1'b0, m0, m1, e0, e1);
      checks++; if (m0 !== e0)            begin errors++; $display("FAIL rnd%0d_byte0 got %h want %h", n, m0, e0); end
      checks++; if (txn_cnt - t0 !== 1)   begin errors++; $display("FAIL rnd%0d_txn got %0d want 1", n, txn_cnt - t0); end
      checks++; if (last_wr !== b0[7])    begin errors++; $display("FAIL rnd%0d_wr_rdn got %b want %b", n, last_wr, b0[7]); end
      checks++; if (int'(last_addr) !== int'(b0) % NREG)
        begin errors++; $display("FAIL rnd%0d_addr got %0d want %0d", n, last_addr, int'(b0) % NREG); end
      if (b0[7]) begin
        checks++; if (last_wdata !== b1)  begin errors++; $display("FAIL rnd%0d_wdata got %h want %h", n, last_wdata, b1); end
      end else begin
        checks++; if (m1 !== e1)          begin errors++; $display("FAIL rnd%0d_rdata got %h want %h", n, m1, e1); end
      end
      if (mode == 2) begin
        checks++; if (last_len !== TIMEOUT) begin errors++; $display("FAIL rnd%0d_to_len got %0d want %0d", n, last_len, TIMEOUT); end
      end
    end
  endtask

  task automatic test_we_rule();
    checks++; if (we_bad !== 0) begin errors++; $display("FAIL we_eq_req_and_wr cycles_bad %0d want 0", we_bad); end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_write_read();
    test_timeout();
    test_err();
    test_abort();
    test_rst_mid();
    test_ena_mid();
    test_random();
    test_we_rule();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // global guard against a hung run
  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
